pipeline_mem_arbiter: RTL and testbench

PIPELINE_MEM_ARBITER -- requirements
Module: pipeline_mem_arbiter

---
 rtl/pipeline_mem_arbiter_pkg.sv | 23 ++
 rtl/pipeline_mem_arbiter_counter.sv | 24 ++
 rtl/pipeline_mem_arbiter.sv | 116 +++++++++++
 tb/tb_pipeline_mem_arbiter.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/pipeline_mem_arbiter_pkg.sv
// Shared widths, defaults and encodings for the IF/MEM single-port memory arbiter.
package pipeline_mem_arbiter_pkg;
    localparam int ADDRESS_LEN         = 32;
    localparam int REGISTER_LEN        = 32;
    localparam int MEM_WAIT_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACC_IF  = 2'd1,
        ST_ACC_MEM = 2'd2,
        ST_RESP    = 2'd3
    } arb_state_t;

    typedef enum logic {
        GNT_IF  = 1'b0,
        GNT_MEM = 1'b1
    } gnt_t;

    // Counter width able to hold 0..n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction
endpackage

// File: rtl/pipeline_mem_arbiter_counter.sv
// Wait-state counter: cleared outside an access, counts each access cycle, flags the last one.
module mem_wait_counter
    import pipeline_mem_arbiter_pkg::*;
#(
    parameter int MAX = MEM_WAIT_CYCLES_DEF
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_clear,
    input  logic i_en,
    output logic o_tc
);
    localparam int W = cnt_width(MAX);

    logic [W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)     r_cnt <= '0;
        else if (i_clear) r_cnt <= '0;
        else if (i_en)    r_cnt <= r_cnt + 1'b1;
    end

    assign o_tc = (r_cnt == W'(MAX));
endmodule

// File: rtl/pipeline_mem_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one wait-stated memory bus;
// alternates grants under contention and stalls the front end while either side waits.
module pipeline_mem_arbiter
    import pipeline_mem_arbiter_pkg::*;
#(
    parameter int MEM_WAIT_CYCLES = MEM_WAIT_CYCLES_DEF,
    parameter int ADDR_W          = ADDRESS_LEN,
    parameter int DATA_W          = REGISTER_LEN
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_if_req,
    input  logic [ADDR_W-1:0] i_if_addr,
    output logic [DATA_W-1:0] o_if_rdata,
    output logic              o_if_ready,
    input  logic              i_mem_rd_req,
    input  logic              i_mem_wr_req,
    input  logic [ADDR_W-1:0] i_mem_addr,
    input  logic [DATA_W-1:0] i_mem_wdata,
    output logic [DATA_W-1:0] o_mem_rdata,
    output logic              o_mem_ready,
    output logic              o_freeze,
    output logic              o_ext_en,
    output logic              o_ext_we,
    output logic [ADDR_W-1:0] o_ext_addr,
    output logic [DATA_W-1:0] o_ext_wdata,
    input  logic [DATA_W-1:0] i_ext_rdata
);
    arb_state_t        r_state;
    gnt_t              r_last_grant;
    logic              r_ext_en, r_ext_we;
    logic [ADDR_W-1:0] r_ext_addr;
    logic [DATA_W-1:0] r_ext_wdata;
    logic              r_if_ready, r_mem_ready;
    logic [DATA_W-1:0] r_if_rdata, r_mem_rdata;

    logic w_in_acc, w_tc, w_req_mem, w_gnt_mem;

    assign w_in_acc  = (r_state == ST_ACC_IF) || (r_state == ST_ACC_MEM);
    assign w_req_mem = i_mem_rd_req | i_mem_wr_req;
    // MEM wins when alone, or when both wait and IF had the previous grant.
    assign w_gnt_mem = w_req_mem & (~i_if_req | (r_last_grant == GNT_IF));

    mem_wait_counter #(.MAX(MEM_WAIT_CYCLES)) u_wait (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clear (~w_in_acc),
        .i_en    (w_in_acc),
        .o_tc    (w_tc)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state      <= ST_IDLE;
            r_last_grant <= GNT_IF;
            r_ext_en     <= 1'b0;
            r_ext_we     <= 1'b0;
            r_ext_addr   <= '0;
            r_ext_wdata  <= '0;
            r_if_ready   <= 1'b0;
            r_mem_ready  <= 1'b0;
            r_if_rdata   <= '0;
            r_mem_rdata  <= '0;
        end else begin
            r_if_ready  <= 1'b0;
            r_mem_ready <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_if_req || w_req_mem) begin
                        r_ext_en <= 1'b1;
                        if (w_gnt_mem) begin
                            r_state      <= ST_ACC_MEM;
                            r_last_grant <= GNT_MEM;
                            r_ext_addr   <= i_mem_addr;
                            r_ext_wdata  <= i_mem_wdata;
                            r_ext_we     <= i_mem_wr_req;  // store wins if both asserted
                        end else begin
                            r_state      <= ST_ACC_IF;
                            r_last_grant <= GNT_IF;
                            r_ext_addr   <= i_if_addr;
                            r_ext_wdata  <= '0;
                            r_ext_we     <= 1'b0;
                        end
                    end
                end
                ST_ACC_IF, ST_ACC_MEM: begin
                    if (w_tc) begin
                        r_state  <= ST_RESP;
                        r_ext_en <= 1'b0;
                        r_ext_we <= 1'b0;
                        if (r_state == ST_ACC_IF) begin
                            r_if_ready <= 1'b1;
                            r_if_rdata <= i_ext_rdata;
                        end else begin
                            r_mem_ready <= 1'b1;
                            if (!r_ext_we) r_mem_rdata <= i_ext_rdata;
                        end
                    end
                end
                // Unconditional return so a requester dropping at its ready edge is not re-served.
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign o_freeze    = i_rst_n & ((i_if_req & ~r_if_ready) | (w_req_mem & ~r_mem_ready));
    assign o_ext_en    = r_ext_en;
    assign o_ext_we    = r_ext_we;
    assign o_ext_addr  = r_ext_addr;
    assign o_ext_wdata = r_ext_wdata;
    assign o_if_ready  = r_if_ready;
    assign o_if_rdata  = r_if_rdata;
    assign o_mem_ready = r_mem_ready;
    assign o_mem_rdata = r_mem_rdata;
endmodule

// File: tb/tb_pipeline_mem_arbiter.sv
// Directed bench for pipeline_mem_arbiter with MEM_WAIT_CYCLES=2 and a small word memory model.
module tb_pipeline_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, mem_rd_req, mem_wr_req;
    logic [31:0] if_addr, mem_addr, mem_wdata;
    logic [31:0] if_rdata, mem_rdata, ext_addr, ext_wdata, ext_rdata;
    logic        if_ready, mem_ready, freeze, ext_en, ext_we;

    always #5 clk = ~clk;

    pipeline_mem_arbiter #(.MEM_WAIT_CYCLES(2), .ADDR_W(32), .DATA_W(32)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_if_req(if_req), .i_if_addr(if_addr), .o_if_rdata(if_rdata), .o_if_ready(if_ready),
        .i_mem_rd_req(mem_rd_req), .i_mem_wr_req(mem_wr_req), .i_mem_addr(mem_addr),
        .i_mem_wdata(mem_wdata), .o_mem_rdata(mem_rdata), .o_mem_ready(mem_ready),
        .o_freeze(freeze), .o_ext_en(ext_en), .o_ext_we(ext_we), .o_ext_addr(ext_addr),
        .o_ext_wdata(ext_wdata), .i_ext_rdata(ext_rdata)
    );

    // Word memory: preloaded on the first clock, written on enabled store cycles.
    logic [31:0] mem [0:1023];
    bit          pre_done = 1'b0;
    always @(posedge clk) begin
        if (!pre_done) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'h0;
            mem[4]   <= 32'hE3A01005;
            mem[8]   <= 32'hA5A50008;
            pre_done <= 1'b1;
        end else if (ext_en && ext_we) begin
            mem[ext_addr[11:2]] <= ext_wdata;
        end
    end
    assign ext_rdata = mem[ext_addr[11:2]];

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int mr, ir, n_we, n_rdy, ov;
        int ord[$];
        int cyc[$];

        rst_n = 1'b0; if_req = 1'b1; mem_rd_req = 1'b0; mem_wr_req = 1'b0;
        if_addr = 32'h0; mem_addr = 32'h0; mem_wdata = 32'h0;
        repeat (3) step();
        chk("rst_freeze", freeze, 0);
        chk("rst_ext_en", ext_en, 0);
        chk("rst_ready", {if_ready, mem_ready}, 0);
        chk("rst_rdata", {if_rdata, mem_rdata}, 0);
        if_req = 1'b0;
        step();

        // Fetch only: grant at the first edge after release
        rst_n = 1'b1; if_req = 1'b1; if_addr = 32'h10;
        for (int c = 0; c <= 6; c++) begin
            #1;
            chk($sformatf("fetch_en_c%0d", c), ext_en, (c >= 1 && c <= 3));
            chk($sformatf("fetch_rdy_c%0d", c), if_ready, (c == 4));
            chk($sformatf("fetch_frz_c%0d", c), freeze, (c <= 3));
            if (c == 1) chk("fetch_addr", ext_addr, 32'h10);
            if (c == 4) chk("fetch_rdata", if_rdata, 32'hE3A01005);
            step();
            if (c == 4) if_req = 1'b0;
        end

        // Store, with live wdata changed mid-access
        mem_wr_req = 1'b1; mem_addr = 32'h400; mem_wdata = 32'hDEADBEEF;
        n_we = 0; n_rdy = 0;
        for (int c = 0; c <= 6; c++) begin
            #1;
            if (ext_we) n_we++;
            if (mem_ready) n_rdy++;
            if (c == 1) chk("store_wdata", ext_wdata, 32'hDEADBEEF);
            if (c == 2) begin chk("store_frz", freeze, 1); mem_wdata = 32'h0; end
            if (c == 4) chk("store_rdy_c4", mem_ready, 1);
            step();
            if (c == 4) mem_wr_req = 1'b0;
        end
        chk("store_we_cycles", n_we, 3);
        chk("store_rdy_pulses", n_rdy, 1);
        chk("store_mem", mem[256], 32'hDEADBEEF);
        chk("store_no_rdata", mem_rdata, 0);

        // Contention right after reset: MEM first, IF five cycles later
        rst_n = 1'b0; step(); step(); rst_n = 1'b1;
        if_req = 1'b1; if_addr = 32'h400; mem_rd_req = 1'b1; mem_addr = 32'h10;
        mr = -1; ir = -1;
        for (int c = 0; c <= 12; c++) begin
            #1;
            if (mem_ready) mr = c;
            if (if_ready) ir = c;
            step();
            if (c == mr) mem_rd_req = 1'b0;
            if (c == ir) if_req = 1'b0;
        end
        chk("cont_mem_cycle", mr, 4);
        chk("cont_if_cycle", ir, 9);
        chk("cont_mem_rdata", mem_rdata, 32'hE3A01005);
        chk("cont_if_rdata", if_rdata, 32'hDEADBEEF);

        // Fairness: both held continuously
        if_req = 1'b1; if_addr = 32'h10; mem_rd_req = 1'b1; mem_addr = 32'h20;
        for (int c = 0; c <= 19; c++) begin
            #1;
            if (mem_ready) begin ord.push_back(1); cyc.push_back(c); end
            if (if_ready)  begin ord.push_back(0); cyc.push_back(c); end
            step();
        end
        if_req = 1'b0; mem_rd_req = 1'b0;
        chk("fair_count", ord.size(), 4);
        for (int i = 0; i < 4; i++) begin
            ov = (i < ord.size()) ? ord[i] : 99;
            chk($sformatf("fair_order_%0d", i), ov, (i % 2 == 0) ? 1 : 0);
            ov = (i < cyc.size()) ? cyc[i] : 99;
            chk($sformatf("fair_cycle_%0d", i), ov, 4 + 5 * i);
        end
        chk("fair_mem_rdata", mem_rdata, 32'hA5A50008);
        step(); step();

        // Reset in the second ACC_MEM cycle
        mem_rd_req = 1'b1; mem_addr = 32'h10;
        step(); step();
        #2; rst_n = 1'b0; #1;
        chk("rmid_ext_en", ext_en, 0);
        chk("rmid_ext_bus", {ext_we, ext_addr, ext_wdata}, 0);
        chk("rmid_rdata", {if_rdata, mem_rdata}, 0);
        chk("rmid_frz_rdy", {freeze, mem_ready, if_ready}, 0);
        n_rdy = 0;
        for (int c = 0; c < 2; c++) begin
            step();
            if (mem_ready) n_rdy++;
        end
        chk("rmid_no_ready", n_rdy, 0);
        rst_n = 1'b1;
        mr = -1;
        for (int c = 0; c <= 5; c++) begin
            #1;
            if (mem_ready) mr = c;
            step();
            if (c == 4) mem_rd_req = 1'b0;
        end
        chk("rmid_retry_cycle", mr, 4);
        chk("rmid_retry_rdata", mem_rdata, 32'hE3A01005);

        // Illegal rd+wr: write performed, load data untouched
        mem_rd_req = 1'b1; mem_wr_req = 1'b1; mem_addr = 32'h800; mem_wdata = 32'h12345678;
        n_we = 0; mr = -1;
        for (int c = 0; c <= 5; c++) begin
            #1;
            if (ext_we) n_we++;
            if (mem_ready) mr = c;
            step();
            if (c == 4) begin mem_rd_req = 1'b0; mem_wr_req = 1'b0; end
        end
        chk("ill_we_cycles", n_we, 3);
        chk("ill_rdy_cycle", mr, 4);
        chk("ill_mem", mem[512], 32'h12345678);
        chk("ill_rdata_kept", mem_rdata, 32'hE3A01005);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
